// File: rtl/tlu_pkg.sv
// Shared definitions for the DUT side of the TLU trigger link:
// FSM encoding, operating modes and the clock half-period floor.
package tlu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WAIT_LOW,
        CLK_HI,
        CLK_LO,
        REARM
    } state_t;

    localparam logic [1:0] MODE_SIMPLE    = 2'd0;
    localparam logic [1:0] MODE_HANDSHAKE = 2'd1;
    localparam logic [1:0] MODE_DATA      = 2'd2;

    localparam int CLK_HALF_MIN = 4;

    // Short half periods would not leave the 2-FF synchroniser enough settling time.
    function automatic logic [7:0] eff_half(input logic [7:0] half);
        return (half < 8'(CLK_HALF_MIN)) ? 8'(CLK_HALF_MIN) : half;
    endfunction

endpackage

// File: rtl/tlu_sync_edge.sv
// Two-flop synchroniser for an asynchronous TLU line, plus a rising-edge
// detect on the synchronised level.
module tlu_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/tlu_dut_handshake_rx.sv
// DUT-side receiver for the TLU trigger link: accepts triggers, runs the
// BUSY/CLOCK handshake, shifts in the serial trigger ID and publishes it.
module tlu_dut_handshake_rx
    import tlu_pkg::*;
#(
    parameter int TRIG_ID_BITS = 15,
    parameter int CNT_BITS     = 32
) (
    input  logic                    SYS_CLK,
    input  logic                    SYS_RST_N,
    input  logic                    CONF_EN,
    input  logic [1:0]              CONF_MODE,
    input  logic [7:0]              CONF_CLK_HALF,
    input  logic [15:0]             CONF_TIMEOUT,
    input  logic                    TLU_TRIGGER,
    input  logic                    TLU_RESET,
    input  logic                    EXT_VETO,
    output logic                    TLU_BUSY,
    output logic                    TLU_CLOCK,
    output logic                    TRIG_PULSE,
    output logic                    TRIG_VALID,
    output logic [TRIG_ID_BITS-1:0] TRIG_ID,
    input  logic                    TRIG_READY,
    output logic                    TLU_RESET_PULSE,
    output logic                    TIMEOUT_ERR,
    output logic [7:0]              LOST_CNT,
    output logic [CNT_BITS-1:0]     TRIG_CNT
);

    localparam int IDX_W = (TRIG_ID_BITS > 1) ? $clog2(TRIG_ID_BITS) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [15:0]             cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [TRIG_ID_BITS-1:0] id_shift;
    logic [TRIG_ID_BITS-1:0] id_next;
    logic [TRIG_ID_BITS-1:0] pub_id;
    logic                    publish;
    logic                    trig_lvl;
    logic                    trig_rise;
    logic                    rst_lvl;
    logic                    hs_mode;
    logic                    data_mode;
    logic                    half_last;
    logic                    timeout_hit;
    logic                    last_bit;

    tlu_sync_edge u_sync_trig (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .din   (TLU_TRIGGER),
        .level (trig_lvl),
        .rise  (trig_rise)
    );

    tlu_sync_edge u_sync_rst (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .din   (TLU_RESET),
        .level (rst_lvl),
        .rise  (TLU_RESET_PULSE)
    );

    // Mode 3 decodes like the data handshake.
    assign hs_mode     = (CONF_MODE != MODE_SIMPLE);
    assign data_mode   = CONF_MODE[1];
    assign half_last   = (cnt == 16'(eff_half(CONF_CLK_HALF)) - 16'd1);
    assign timeout_hit = (CONF_TIMEOUT != 16'd0) && (cnt == CONF_TIMEOUT - 16'd1);
    assign last_bit    = (bit_idx == IDX_W'(TRIG_ID_BITS - 1));

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) state <= IDLE;
        else            state <= state_nxt;
    end

    // NOTE: every combinational output is given a default first so that no
    // path through the case statement leaves it unassigned (a latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (trig_rise && CONF_EN && !EXT_VETO) state_nxt = ACCEPT;
            ACCEPT:   state_nxt = hs_mode ? WAIT_LOW : REARM;
            WAIT_LOW: begin
                if (!trig_lvl)        state_nxt = data_mode ? CLK_HI : REARM;
                else if (timeout_hit) state_nxt = REARM;
            end
            CLK_HI:   if (half_last) state_nxt = CLK_LO;
            CLK_LO:   if (half_last) state_nxt = last_bit ? REARM : CLK_HI;
            REARM:    if (!trig_lvl) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        id_next          = id_shift;
        id_next[bit_idx] = trig_lvl;
        TRIG_PULSE       = (state == ACCEPT);
        TLU_CLOCK        = (state == CLK_HI);
        TLU_BUSY         = EXT_VETO | (hs_mode && state != IDLE);
        TIMEOUT_ERR      = (state == WAIT_LOW) && trig_lvl && timeout_hit;
        publish          = 1'b0;
        pub_id           = id_next;
        case (state)
            ACCEPT: if (!hs_mode) begin
                publish = 1'b1;
                pub_id  = TRIG_ID_BITS'(TRIG_CNT + CNT_BITS'(1));
            end
            WAIT_LOW: if (!trig_lvl && !data_mode) begin
                publish = 1'b1;
                pub_id  = TRIG_CNT[TRIG_ID_BITS-1:0];
            end
            CLK_LO: publish = half_last && last_bit;
            default: ;
        endcase
    end

    // Phase/timeout counter restarts on every state change and saturates.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            cnt      <= '0;
            bit_idx  <= '0;
            id_shift <= '0;
        end else begin
            if (state_nxt != state) cnt <= '0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            if (state == ACCEPT) begin
                bit_idx  <= '0;
                id_shift <= '0;
            end else if (state == CLK_LO && half_last) begin
                bit_idx  <= bit_idx + IDX_W'(1);
                id_shift <= id_next;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            TRIG_CNT   <= '0;
            LOST_CNT   <= '0;
            TRIG_VALID <= 1'b0;
            TRIG_ID    <= '0;
        end else begin
            if (TLU_RESET_PULSE)     TRIG_CNT <= '0;
            else if (state == ACCEPT) TRIG_CNT <= TRIG_CNT + CNT_BITS'(1);
            if (TLU_RESET_PULSE)
                LOST_CNT <= '0;
            else if (publish && TRIG_VALID && !TRIG_READY && LOST_CNT != 8'hFF)
                LOST_CNT <= LOST_CNT + 8'd1;
            // A publish in the same cycle as a consumer handshake keeps valid high.
            if (publish) begin
                TRIG_VALID <= 1'b1;
                TRIG_ID    <= pub_id;
            end else if (TRIG_READY) begin
                TRIG_VALID <= 1'b0;
            end
        end
    end

endmodule
